// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared types and default constants for the UART transmit buffer
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int UART_FIFO_DEPTH  = 16;
  localparam int UART_SYNC_STAGES = 2;

  // Launch sequencer states; WAIT_IDLE is the post-reset entry state.
  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SEND      = 2'd2,
    RELEASE   = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
//  Module   : sync_bit
//  Brief    : Multi-flop single-bit synchroniser, asynchronously cleared to 0
//  Revision : 1.0  initial release
// ============================================================================
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the foreign-domain bit through the flop chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : CPU-side byte FIFO feeding a UART send/DataOut/busy interface
//             with a send pulse-and-release handshake
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = UART_FIFO_DEPTH,
  parameter int AW          = $clog2(DEPTH),
  parameter int SYNC_STAGES = UART_SYNC_STAGES
) (
  input  logic          clk_CPU,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          ovf_clr,
  input  logic          uart_busy,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          uart_send,
  output logic [7:0]    uart_data,
  output logic          tx_active
);

  localparam int LW = AW + 1;
  localparam int PW = $clog2(SYNC_STAGES + 1);

  // Storage is deliberately left without reset.
  logic [7:0]    mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          full_q,   full_d;
  logic          empty_q,  empty_d;
  logic          ovf_q,    ovf_d;

  tx_state_e     state_q;
  logic          send_q;
  logic [7:0]    data_q;
  logic [PW-1:0] prime_q;

  logic          busy_s;
  logic          push;
  logic          pop;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_busy_sync (
    .clk_i (clk_CPU),
    .rst_i (rst),
    .d_i   (uart_busy),
    .q_o   (busy_s)
  );

  // A write into a full FIFO is dropped even if a pop frees a slot that cycle.
  assign push = wr_en && !full_q;
  assign pop  = (state_q == IDLE) && !empty_q;

  // Next-state for pointers, occupancy flags and sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
    // A dropped write takes priority over a clear in the same cycle.
    if (wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Register the FIFO bookkeeping.
  always_ff @(posedge clk_CPU or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  // Capture accepted bytes into the storage array.
  always_ff @(posedge clk_CPU) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Launch sequencer with registered send/data outputs.
  always_ff @(posedge clk_CPU or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_IDLE;
      send_q  <= 1'b0;
      data_q  <= 8'h00;
      prime_q <= '0;
    end else begin
      case (state_q)
        WAIT_IDLE: begin
          // The synchroniser restarts from 0 after reset, so its output is
          // only trusted once it has been refilled with live samples.
          if (prime_q != PW'(SYNC_STAGES)) begin
            prime_q <= prime_q + PW'(1);
          end else if (!busy_s) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (!empty_q) begin
            data_q  <= mem_q[rd_ptr_q];
            send_q  <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (busy_s) begin
            send_q  <= 1'b0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (!busy_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          send_q  <= 1'b0;
          state_q <= WAIT_IDLE;
        end
      endcase
    end
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign uart_send = send_q;
  assign uart_data = data_q;
  assign tx_active = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Brief    : Self-checking bench for uart_tx_fifo with a queue-based model
//             and a behavioural UART busy responder
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DEPTH   = 16;
  localparam int SYNC    = 2;
  localparam int U_DELAY = 3;

  logic       clk_CPU   = 1'b0;
  logic       rst       = 1'b0;
  logic       wr_en     = 1'b0;
  logic [7:0] wr_data   = 8'h00;
  logic       ovf_clr   = 1'b0;
  logic       uart_busy = 1'b0;
  logic       full, empty, overflow, uart_send, tx_active;
  logic [4:0] level;
  logic [7:0] uart_data;

  int         n_chk = 0;
  int         n_err = 0;

  logic [7:0] mq[$];
  logic [7:0] rx[$];
  bit         m_ovf      = 1'b0;
  int         acc_cnt    = 0;
  bit         prev_send  = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  int         u_phase    = 0;
  int         u_cnt      = 0;
  int         u_hold_min = 20;
  int         u_hold_max = 20;
  bit         u_busy     = 1'b0;
  bit         force_busy = 1'b0;
  bit         saw_busy   = 1'b0;

  uart_tx_fifo dut (
    .clk_CPU   (clk_CPU),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .ovf_clr   (ovf_clr),
    .uart_busy (uart_busy),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .uart_send (uart_send),
    .uart_data (uart_data),
    .tx_active (tx_active)
  );

  always #5 clk_CPU = ~clk_CPU;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_busy();
    uart_busy = u_busy | force_busy;
  endtask

  // One clock: update model from pre-edge inputs, then sample and compare.
  task automatic step();
    int  c;
    bit  rise;
    bit  fall;
    c = mq.size();
    if (wr_en && c < DEPTH) begin
      mq.push_back(wr_data);
      acc_cnt++;
    end
    if (wr_en && c == DEPTH) m_ovf = 1'b1;
    else if (ovf_clr)        m_ovf = 1'b0;

    @(posedge clk_CPU);
    #1;
    rise = uart_send && !prev_send;
    fall = !uart_send && prev_send;
    if (rise) begin
      saw_busy = 1'b0;
      check("launch_busy_low", 32'(uart_busy), 32'd0);
      check("launch_uart_idle", u_phase, 32'd0);
      check("launch_has_data", 32'(mq.size() != 0), 32'd1);
      if (mq.size() != 0) begin
        check("uart_data", 32'(uart_data), 32'(mq[0]));
        rx.push_back(uart_data);
        void'(mq.pop_front());
      end
    end else begin
      check("data_hold", 32'(uart_data), 32'(prev_data));
    end
    if (fall) check("send_fall_after_busy", 32'(saw_busy), 32'd1);
    check("level", 32'(level), 32'(mq.size()));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    prev_send = uart_send;
    prev_data = uart_data;

    // Behavioural UART: busy rises U_DELAY cycles after send, holds, drops.
    case (u_phase)
      0: if (uart_send) begin u_phase = 1; u_cnt = U_DELAY; end
      1: begin
        u_cnt--;
        if (u_cnt == 0) begin
          u_busy  = 1'b1;
          u_phase = 2;
          u_cnt   = int'($urandom_range(u_hold_max, u_hold_min));
        end
      end
      2: begin
        u_cnt--;
        if (u_cnt == 0) begin u_busy = 1'b0; u_phase = 3; end
      end
      default: if (!uart_send) u_phase = 0;
    endcase
    drive_busy();
    if (uart_busy) saw_busy = 1'b1;
  endtask

  task automatic do_reset(input bit busy);
    force_busy = busy;
    u_busy     = 1'b0;
    u_phase    = 0;
    drive_busy();
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_send", 32'(uart_send), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", 32'(uart_data), 32'd0);
    check("rst_active", 32'(tx_active), 32'd1);
    acc_cnt  -= mq.size();
    mq.delete();
    m_ovf     = 1'b0;
    prev_send = 1'b0;
    prev_data = 8'h00;
    saw_busy  = 1'b0;
    repeat (2) @(posedge clk_CPU);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!tx_active && empty && u_phase == 0 && !uart_busy) break;
      step();
    end
    check(tag, 32'({tx_active, empty, u_phase == 0}), 32'(3'b011));
  endtask

  initial begin
    int  start;
    int  base;
    bit  did6;

    // Reset release with an idle UART; IDLE reached after SYNC+1 cycles.
    do_reset(1'b0);
    for (int i = 1; i <= SYNC + 1; i++) begin
      step();
      check("t1_active", 32'(tx_active), 32'(i <= SYNC));
    end
    check("t1_send", 32'(uart_send), 32'd0);

    // Single byte latency and full handshake.
    u_hold_min = 20; u_hold_max = 20;
    wait_idle("t2_idle", 100);
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    check("t2_n1_send", 32'(uart_send), 32'd0);
    check("t2_n1_empty", 32'(empty), 32'd0);
    step();
    check("t2_n2_send", 32'(uart_send), 32'd1);
    check("t2_n2_data", 32'(uart_data), 32'hA5);
    wait_idle("t2_done", 100);

    // Simultaneous push and pop at level 5.
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom);
      step();
    end
    wr_en = 1'b0;
    check("t4_level5", 32'(level), 32'd5);
    for (int i = 0; i < 100; i++) begin
      if (!tx_active) break;
      step();
    end
    check("t4_idle", 32'(tx_active), 32'd0);
    wr_en = 1'b1; wr_data = 8'($urandom);
    step();
    wr_en = 1'b0;
    check("t4_pushpop", 32'(level), 32'd5);

    // Forty lossless bytes through the FIFO to exercise pointer wrap.
    u_hold_min = 1; u_hold_max = 4;
    start = acc_cnt;
    for (int i = 0; i < 3000 && (acc_cnt - start) < 40; i++) begin
      wr_en   = (mq.size() < DEPTH) && ($urandom_range(3, 0) != 0);
      wr_data = 8'($urandom);
      step();
    end
    wr_en = 1'b0;
    check("t4_40_written", 32'((acc_cnt - start) >= 40), 32'd1);
    wait_idle("t4_drain", 2000);
    check("t4_delivered", 32'(rx.size()), 32'(acc_cnt));

    // Unconstrained random traffic with drops and overflow clears.
    for (int i = 0; i < 400; i++) begin
      wr_en   = ($urandom_range(1, 0) != 0);
      wr_data = 8'($urandom);
      ovf_clr = ($urandom_range(15, 0) == 0);
      step();
    end
    wr_en = 1'b0; ovf_clr = 1'b0;
    wait_idle("rnd_drain", 2000);
    check("rnd_delivered", 32'(rx.size()), 32'(acc_cnt));

    // Reset while in SEND with the UART busy.
    u_hold_min = 20; u_hold_max = 20;
    wr_en = 1'b1; wr_data = 8'($urandom);
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (uart_send) break;
      step();
    end
    check("t5_in_send", 32'(uart_send), 32'd1);
    force_busy = 1'b1;
    drive_busy();
    wr_en = 1'b1; wr_data = 8'($urandom);
    step();
    wr_en = 1'b0;
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      wr_en   = (i < 3);
      wr_data = 8'($urandom);
      step();
      check("t5_wait_idle", 32'(tx_active), 32'd1);
    end
    wr_en = 1'b0;
    check("t5_queued", 32'(level), 32'd3);
    force_busy = 1'b0;
    drive_busy();
    for (int i = 1; i <= SYNC + 1; i++) begin
      step();
      check("t5_exit", 32'(tx_active), 32'(i <= SYNC));
    end
    u_hold_min = 1; u_hold_max = 4;
    wait_idle("t5_drain", 500);

    // Overflow with a stalled UART, then write-while-full during a pop.
    do_reset(1'b1);
    for (int i = 0; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    check("t3_level", 32'(level), 32'd16);
    check("t3_full", 32'(full), 32'd1);
    check("t3_ovf", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    base = rx.size();
    force_busy = 1'b0;
    drive_busy();
    did6 = 1'b0;
    for (int i = 0; i < 50 && !did6; i++) begin
      if (!tx_active && full) begin
        wr_en = 1'b1; wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        check("t6_level", 32'(level), 32'd15);
        check("t6_ovf", 32'(overflow), 32'd1);
        check("t6_send", 32'(uart_send), 32'd1);
        did6 = 1'b1;
      end else begin
        step();
      end
    end
    check("t6_hit", 32'(did6), 32'd1);
    wait_idle("t3_drain", 1000);
    check("t3_rx_count", 32'(rx.size() - base), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < rx.size()) check("t3_order", 32'(rx[base + i]), 32'(i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
